// File: rtl/cnn_pkg.sv
// Shared CNN definitions: arithmetic mode selectors and sizing helpers.
package cnn_pkg;

    localparam int ARITH_FLOAT = 0;
    localparam int ARITH_FIXED = 1;

    // Counter width for a TERMS-deep group, never narrower than one bit.
    function automatic int cnt_width(input int terms);
        return (terms <= 2) ? 1 : $clog2(terms);
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational adder: two's-complement wrap in fixed mode, truncating
// IEEE-style add in float mode (M counts the hidden bit; denormals flush).
module adder
    import cnn_pkg::*;
#(
    parameter int ARITH_TYPE = ARITH_FLOAT,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 24
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    generate
        if (ARITH_TYPE == ARITH_FIXED) begin : g_fixed
            // Plain modular add; overflow wraps at DATA_WIDTH.
            assign y = a + b;
        end else begin : g_float
            localparam int FW = M - 1;   // stored fraction bits
            localparam int XW = M + 3;   // hidden + fraction + 3 guard bits

            logic          s_big, s_sml;
            logic [E-1:0]  e_big, e_sml;
            logic [FW-1:0] f_big, f_sml;
            logic [XW-1:0] m_big, m_sml, m_sh, norm;
            logic [XW:0]   sum;
            logic [E-1:0]  diff;
            int            lz;
            int            exp_i;
            logic          found;

            // Align the smaller operand, add/subtract, renormalise, repack.
            always_comb begin
                if (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) begin
                    s_big = a[DATA_WIDTH-1]; e_big = a[FW+E-1:FW]; f_big = a[FW-1:0];
                    s_sml = b[DATA_WIDTH-1]; e_sml = b[FW+E-1:FW]; f_sml = b[FW-1:0];
                end else begin
                    s_big = b[DATA_WIDTH-1]; e_big = b[FW+E-1:FW]; f_big = b[FW-1:0];
                    s_sml = a[DATA_WIDTH-1]; e_sml = a[FW+E-1:FW]; f_sml = a[FW-1:0];
                end
                m_big = {(|e_big), f_big, 3'b000};
                m_sml = {(|e_sml), f_sml, 3'b000};
                diff  = e_big - e_sml;
                m_sh  = (int'(diff) >= XW) ? '0 : (m_sml >> diff);

                if (s_big == s_sml) sum = {1'b0, m_big} + {1'b0, m_sh};
                else                sum = {1'b0, m_big} - {1'b0, m_sh};

                exp_i = int'(e_big);
                lz    = 0;
                found = 1'b0;
                norm  = sum[XW-1:0];
                if (sum[XW]) begin
                    norm  = sum[XW:1];
                    exp_i = exp_i + 1;
                end else begin
                    for (int i = XW - 1; i >= 0; i--) begin
                        if (!found && sum[i]) begin
                            lz    = XW - 1 - i;
                            found = 1'b1;
                        end
                    end
                    norm  = sum[XW-1:0] << lz;
                    exp_i = exp_i - lz;
                end

                if (sum == '0)
                    y = '0;
                else if (exp_i <= 0)
                    y = {s_big, {(DATA_WIDTH-1){1'b0}}};
                else if (exp_i >= (1 << E) - 1)
                    y = {s_big, {E{1'b1}}, {FW{1'b0}}};
                else
                    y = {s_big, exp_i[E-1:0], norm[XW-2:3]};
            end
        end
    endgenerate

endmodule

// File: rtl/conv_accumulator.sv
// Folds each group of TERMS products into one sum and hands it downstream
// through a single-entry output register with valid/ready.
module conv_accumulator
    import cnn_pkg::*;
#(
    parameter int ARITH_TYPE = ARITH_FLOAT,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 24,
    parameter int TERMS      = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int          CW   = cnt_width(TERMS);
    localparam logic [CW-1:0] LAST = CW'(TERMS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] sum;
    logic                  is_last, accept;

    adder #(
        .ARITH_TYPE (ARITH_TYPE),
        .DATA_WIDTH (DATA_WIDTH),
        .E          (E),
        .M          (M)
    ) u_adder (
        .a (acc_q),
        .b (in_data),
        .y (sum)
    );

    // Handshake plus next-state for counter, accumulator and output register.
    always_comb begin
        is_last     = (cnt_q == LAST);
        // Partial terms keep flowing; only the closing term waits on a full slot.
        in_ready    = !clear && (!is_last || !out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            if (is_last) begin
                out_data_d  = (TERMS == 1) ? in_data : sum;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else if (cnt_q == '0) begin
                // First term loads directly so float groups never see a -0/+0 add.
                acc_d = in_data;
                cnt_d = CW'(1);
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset discards partial sums and any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench: five accumulator instances covering fixed/float, backpressure,
// single-term groups, clear, wrap and asynchronous reset.
module tb_conv_accumulator;

    logic        clk = 1'b0;
    logic [4:0]  rst, clr, iv, ordy;
    logic [4:0]  ir, ov;
    logic [31:0] id [5];
    logic [31:0] od [5];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // 0: fixed T4   1: float T3   2: fixed T2   3: fixed T1   4: fixed T3
    conv_accumulator #(.ARITH_TYPE(1), .TERMS(4)) u0 (
        .clk(clk), .reset(rst[0]), .clear(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));
    conv_accumulator #(.ARITH_TYPE(0), .TERMS(3)) u1 (
        .clk(clk), .reset(rst[1]), .clear(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));
    conv_accumulator #(.ARITH_TYPE(1), .TERMS(2)) u2 (
        .clk(clk), .reset(rst[2]), .clear(clr[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));
    conv_accumulator #(.ARITH_TYPE(1), .TERMS(1)) u3 (
        .clk(clk), .reset(rst[3]), .clear(clr[3]), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_data(id[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]));
    conv_accumulator #(.ARITH_TYPE(1), .TERMS(3)) u4 (
        .clk(clk), .reset(rst[4]), .clear(clr[4]), .in_valid(iv[4]), .in_ready(ir[4]),
        .in_data(id[4]), .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(od[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic v, input logic [31:0] d, input logic r);
        iv[k]   = v;
        id[k]   = d;
        ordy[k] = r;
        #1;
    endtask

    // Push one term through instance k with out_ready high.
    task automatic push(input int k, input logic [31:0] d);
        drv(k, 1'b1, d, 1'b1);
        tick();
    endtask

    initial begin
        rst = '1; clr = '0; iv = '0; ordy = '0;
        for (int k = 0; k < 5; k++) id[k] = '0;
        tick();
        chk("rst_ov", {31'b0, ov[0]}, 32'd0);
        chk("rst_od", od[0], 32'd0);
        rst = '0;
        tick();
        chk("rst_ir", {31'b0, ir[0]}, 32'd1);

        // Fixed T4: 1..4 -> 10, then 5..8 -> 26 with no gap.
        push(0, 1); push(0, 2); push(0, 3);
        chk("t4_nov", {31'b0, ov[0]}, 32'd0);
        push(0, 4);
        chk("t4_ov1", {31'b0, ov[0]}, 32'd1);
        chk("t4_sum1", od[0], 32'd10);
        push(0, 5);
        chk("t4_pulse", {31'b0, ov[0]}, 32'd0);
        push(0, 6); push(0, 7); push(0, 8);
        chk("t4_ov2", {31'b0, ov[0]}, 32'd1);
        chk("t4_sum2", od[0], 32'd26);
        drv(0, 1'b0, 0, 1'b1); tick();
        chk("t4_idle", {31'b0, ov[0]}, 32'd0);

        // Float T3: 1.0 + 2.0 + 0.5 = 3.5
        push(1, 32'h3F800000); push(1, 32'h40000000); push(1, 32'h3F000000);
        chk("flt_ov", {31'b0, ov[1]}, 32'd1);
        chk("flt_sum", od[1], 32'h40600000);
        drv(1, 1'b0, 0, 1'b1);

        // Backpressure T2
        push(2, 1); push(2, 2);
        chk("bp_sum1", od[2], 32'd3);
        drv(2, 1'b1, 10, 1'b0);
        chk("bp_ir10", {31'b0, ir[2]}, 32'd1);
        tick();
        chk("bp_hold1", od[2], 32'd3);
        drv(2, 1'b1, 20, 1'b0);
        chk("bp_ir20", {31'b0, ir[2]}, 32'd0);
        tick();
        chk("bp_ovh", {31'b0, ov[2]}, 32'd1);
        chk("bp_hold2", od[2], 32'd3);
        tick();
        chk("bp_hold3", od[2], 32'd3);
        drv(2, 1'b1, 20, 1'b1);
        chk("bp_ir_rel", {31'b0, ir[2]}, 32'd1);
        tick();
        chk("bp_ov2", {31'b0, ov[2]}, 32'd1);
        chk("bp_sum2", od[2], 32'd30);
        drv(2, 1'b0, 0, 1'b1); tick();
        chk("bp_drain", {31'b0, ov[2]}, 32'd0);

        // TERMS = 1
        push(3, 7);
        chk("t1_a", od[3], 32'd7);
        chk("t1_ova", {31'b0, ov[3]}, 32'd1);
        push(3, 9);
        chk("t1_b", od[3], 32'd9);
        chk("t1_ovb", {31'b0, ov[3]}, 32'd1);
        drv(3, 1'b0, 0, 1'b1); tick();
        chk("t1_idle", {31'b0, ov[3]}, 32'd0);

        // Clear then wrap, T3
        push(4, 5); push(4, 5);
        clr[4] = 1'b1;
        drv(4, 1'b1, 5, 1'b1);
        chk("clr_ir", {31'b0, ir[4]}, 32'd0);
        tick();
        chk("clr_noout", {31'b0, ov[4]}, 32'd0);
        clr[4] = 1'b0;
        push(4, 32'h7FFFFFFF); push(4, 1); push(4, 0);
        chk("wrap_ov", {31'b0, ov[4]}, 32'd1);
        chk("wrap_sum", od[4], 32'h80000000);

        // Async reset with a pending output and a partial group.
        drv(4, 1'b1, 2, 1'b0); tick(); tick(); tick();
        chk("pre_rst_ov", {31'b0, ov[4]}, 32'd1);
        chk("pre_rst_od", od[4], 32'h80000000);
        tick();
        drv(4, 1'b0, 0, 1'b0);
        #1;
        rst[4] = 1'b1;
        #1;
        chk("arst_ov", {31'b0, ov[4]}, 32'd0);
        chk("arst_od", od[4], 32'd0);
        tick();
        rst[4] = 1'b0;
        push(4, 1); push(4, 1); push(4, 1);
        chk("post_rst_ov", {31'b0, ov[4]}, 32'd1);
        chk("post_rst_sum", od[4], 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Streaming accumulator that sits directly downstream of the convolution multiplier stage. It folds each group of `TERMS` products into one sum by feeding its running total and the incoming product through one instance of the existing `adder`. It emits one result per group with a valid/ready handshake to the activation/pooling stage. One term is consumed per cycle, so a full 3x3 window (`TERMS` = 9) takes 9 cycles.

## Interface
Parameters:
- `ARITH_TYPE`, default 0: 0 = floating point, 1 = fixed point; passed to `adder`.
- `DATA_WIDTH`, default 32: width of products and of the sum.
- `E`, default 8: exponent width, float mode.
- `M`, default 24: mantissa width, float mode.
- `TERMS`, default 9: products per output; legal range is 1 or more.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `clear`, input, 1: synchronous abort of the partial group.
- `in_valid`, input, 1: `in_data` holds a product.
- `in_ready`, output, 1: the stage accepts the term this cycle.
- `in_data`, input, `DATA_WIDTH`: product term.
- `out_valid`, output, 1: `out_data` holds a completed sum.
- `out_ready`, input, 1: downstream accepts the sum.
- `out_data`, output, `DATA_WIDTH`: group sum.

## Operation
- State:
  - `cnt`, range 0..`TERMS`-1, width `max(1,$clog2(TERMS))`.
  - `acc`, `DATA_WIDTH` bits.
  - Output holding register `out_data` plus `out_valid`.
- A term is accepted when `in_valid && in_ready`.
- Accepting a term with `cnt == 0` and `TERMS > 1`: `acc <= in_data`, with no add (avoids float -0/+0 artefacts). Then `cnt <= 1`.
- Accepting a term with 0 < `cnt` < `TERMS`-1: `acc <= adder(acc, in_data)`, then `cnt++`.
- Accepting a term with `cnt == TERMS-1` (the last term):
  - `out_data <= adder(acc, in_data)`, or `in_data` when `TERMS == 1`.
  - `out_valid <= 1`, `cnt <= 0`.
- Output release: `out_valid` clears when `out_ready` is high, unless a new last term is accepted in the same cycle. In that case the new sum is loaded and `out_valid` stays 1.
- `in_ready = !clear && (cnt != TERMS-1 || !out_valid || out_ready)`.
  - Partial-group terms keep flowing while an output is pending.
  - Only the last term stalls on a full output register.
- `clear`:
  - Sets `cnt <= 0`; `acc` is don't-care afterwards.
  - Forces `in_ready` low, so no term is accepted that cycle.
  - Never drops or alters a pending `out_valid`/`out_data`.
- Arithmetic:
  - Delegated entirely to `adder`; no rounding or saturation is added.
  - Fixed-point mode wraps two's-complement at `DATA_WIDTH`.
- Reset mid-group: the partial sum and any pending output are discarded.

## Timing
- Reset values:
  - `cnt` = 0, `acc` = 0, `out_data` = 0, `out_valid` = 0.
  - `in_ready` = 1, since it is combinational from reset state.
- Throughput: one term per cycle; one result per `TERMS` cycles with no bubble between groups.
- Latency: `out_valid` rises on the edge that accepts the last term, so it is visible the cycle after that term was presented.
- `adder` is combinational. The critical path is `acc` → adder → `acc`/`out_data`.
- `out_data` is stable while `out_valid && !out_ready`.
- `in_ready` depends combinationally on `out_ready`.

## Structure
- Shared CNN package holds:
  - `ARITH_FLOAT`/`ARITH_FIXED` constants (0/1).
  - A `cnt_width(TERMS)` function returning `max(1,$clog2(TERMS))`.
- One sub-module only: the existing `adder`, instantiated once with `ARITH_TYPE`, `DATA_WIDTH`, `E`, `M` passed through.
- Counter, accumulator and output register stay inline.

## Test plan
- Fixed point, `ARITH_TYPE`=1, `TERMS`=4:
  - Stimulus: stream 1, 2, 3, 4 back-to-back with `out_ready`=1.
  - Required: `out_data`=10, valid for exactly 1 cycle, the cycle after term 4.
  - Then stream 5, 6, 7, 8 → 26 with no gap.
- Float, `TERMS`=3:
  - Stimulus: 0x3F800000, 0x40000000, 0x3F000000 (1.0 + 2.0 + 0.5).
  - Required: `out_data`=0x40600000 (3.5).
- Backpressure, fixed, `TERMS`=2:
  - Stimulus: hold `out_ready`=0 after the first sum (3 = 1+2); send 10, 20.
  - Required: 10 is accepted; `in_ready` drops for 20.
  - Required: `out_data` holds 3 until `out_ready` rises. In that same cycle 20 is accepted and the next cycle shows 30.
- `TERMS`=1, fixed:
  - Stimulus: 7, 9.
  - Required: outputs 7 then 9, one per cycle.
- Clear and wrap, fixed, `TERMS`=3:
  - Stimulus: send 5, 5, assert `clear` with `in_valid`=1 (term not accepted), then send 0x7FFFFFFF, 1, 0.
  - Required: `out_data`=0x80000000.
- Async reset:
  - Stimulus: assert `reset` mid-group and with an output pending.
  - Required: `out_valid`=0 and `out_data`=0 immediately, without waiting for a clock edge.
  - Required: the next group of 1, 1, 1 gives 3.
